// File: rtl/vga_mode_pkg.sv
// Shared types and per-mode timing tables for the VGA mode controller.
// Table index is the 2-bit mode id.
package vga_mode_pkg;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1024X768 = 2'd2,
        MODE_1280X960 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        GEN_RST  = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2,
        WAIT_EOF = 2'd3
    } state_t;

    localparam int MODE_WIDTH  [4] = '{640, 800, 1024, 1280};
    localparam int MODE_HEIGHT [4] = '{480, 600, 768, 960};

    // Last h/v counter value of a frame (total minus one).
    localparam logic [11:0] MODE_LINE   [4] = '{12'd799, 12'd1055, 12'd1343, 12'd1711};
    localparam logic [11:0] MODE_SCREEN [4] = '{12'd524, 12'd627, 12'd805, 12'd993};

endpackage

// File: rtl/vga_eof_detect.sv
// End-of-frame decode: high while the generator sits on the last pixel of the active mode.
// Purely combinational, no backpressure.
module vga_eof_detect
    import vga_mode_pkg::*;
(
    input  mode_t       mode,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    output logic        eof
);

    assign eof = (h_count == MODE_LINE[mode]) && (v_count == MODE_SCREEN[mode]);

endmodule

// File: rtl/vga_mode_controller.sv
// Sequences VGA mode changes: wait for frame end, reset the generator, settle, then relock.
// Requests are accepted only in RUN (ready); optional watchdog under VGA_MODE_TIMEOUT_EN.
module vga_mode_controller
    import vga_mode_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_req_valid,
    input  logic [2:0]         mode_req_id,
    output logic               mode_req_ready,
    input  logic [11:0]        gen_h_count,
    input  logic [11:0]        gen_v_count,
    output logic               gen_reset,
    output logic signed [31:0] width,
    output logic signed [31:0] height,
    output logic               video_enable,
    output logic               mode_locked,
    output logic [1:0]         cur_mode,
    output logic               req_err,
    output logic               timeout_err
);

    if (RESET_CYCLES < 1 || RESET_CYCLES > 15) begin : g_bad_reset_cycles
        $error("RESET_CYCLES out of range 1..15");
    end
    if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 7) begin : g_bad_settle_frames
        $error("SETTLE_FRAMES out of range 1..7");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_t      state, state_nxt;
    mode_t       cur_q, cur_nxt;
    mode_t       pend_q, pend_nxt;
    logic signed [31:0] width_nxt, height_nxt;
    logic [3:0]  rst_cnt, rst_cnt_nxt;
    logic [2:0]  frm_cnt, frm_cnt_nxt;
    logic        req_err_nxt;
    logic        load_new;
    logic        eof;

`ifdef VGA_MODE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            to_err_q, to_err_nxt;
`endif

    vga_eof_detect u_eof (
        .mode    (cur_q),
        .h_count (gen_h_count),
        .v_count (gen_v_count),
        .eof     (eof)
    );

    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur_q;
        pend_nxt    = pend_q;
        width_nxt   = width;
        height_nxt  = height;
        rst_cnt_nxt = rst_cnt;
        frm_cnt_nxt = frm_cnt;
        req_err_nxt = 1'b0;
        load_new    = 1'b0;
`ifdef VGA_MODE_TIMEOUT_EN
        to_cnt_nxt  = to_cnt;
        to_err_nxt  = 1'b0;
`endif
        case (state)
            GEN_RST: begin
                if (rst_cnt == 4'(RESET_CYCLES - 1)) begin
                    state_nxt   = SETTLE;
                    rst_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 4'd1;
                end
            end
            SETTLE: begin
                if (eof) begin
                    if (frm_cnt == 3'(SETTLE_FRAMES - 1)) begin
                        state_nxt   = RUN;
                        frm_cnt_nxt = '0;
                    end else begin
                        frm_cnt_nxt = frm_cnt + 3'd1;
                    end
                end
            end
            RUN: begin
                if (mode_req_valid) begin
                    if (mode_req_id[2]) begin
                        req_err_nxt = 1'b1;
                    end else if (mode_req_id[1:0] != cur_q) begin
                        pend_nxt  = mode_t'(mode_req_id[1:0]);
                        state_nxt = WAIT_EOF;
                    end
                end
            end
            WAIT_EOF: begin
`ifdef VGA_MODE_TIMEOUT_EN
                if (eof) begin
                    load_new = 1'b1;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    load_new   = 1'b1;
                    to_err_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`else
                load_new = eof;
`endif
                // New geometry is loaded on the same edge gen_reset rises.
                if (load_new) begin
                    state_nxt   = GEN_RST;
                    cur_nxt     = pend_q;
                    width_nxt   = MODE_WIDTH[pend_q];
                    height_nxt  = MODE_HEIGHT[pend_q];
                    rst_cnt_nxt = '0;
`ifdef VGA_MODE_TIMEOUT_EN
                    to_cnt_nxt  = '0;
`endif
                end
            end
            default: state_nxt = GEN_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= GEN_RST;
            cur_q   <= MODE_640X480;
            pend_q  <= MODE_640X480;
            width   <= 32'sd640;
            height  <= 32'sd480;
            rst_cnt <= '0;
            frm_cnt <= '0;
            req_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_q   <= cur_nxt;
            pend_q  <= pend_nxt;
            width   <= width_nxt;
            height  <= height_nxt;
            rst_cnt <= rst_cnt_nxt;
            frm_cnt <= frm_cnt_nxt;
            req_err <= req_err_nxt;
        end
    end

`ifdef VGA_MODE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt   <= to_cnt_nxt;
            to_err_q <= to_err_nxt;
        end
    end
    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Status outputs decode straight from the registered state.
    assign mode_req_ready = (state == RUN);
    assign video_enable   = (state == RUN);
    assign mode_locked    = (state == RUN);
    assign gen_reset      = (state == GEN_RST);
    assign cur_mode       = cur_q;

endmodule

// File: tb/tb_vga_mode_controller.sv
// Directed vector bench for vga_mode_controller (default build, watchdog disabled).
module tb_vga_mode_controller;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               mode_req_valid = 1'b0;
    logic [2:0]         mode_req_id = 3'd0;
    logic               mode_req_ready;
    logic [11:0]        gen_h_count = 12'd0;
    logic [11:0]        gen_v_count = 12'd0;
    logic               gen_reset;
    logic signed [31:0] width, height;
    logic               video_enable, mode_locked;
    logic [1:0]         cur_mode;
    logic               req_err, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_mode_controller dut (
        .clk            (clk),
        .reset          (reset),
        .mode_req_valid (mode_req_valid),
        .mode_req_id    (mode_req_id),
        .mode_req_ready (mode_req_ready),
        .gen_h_count    (gen_h_count),
        .gen_v_count    (gen_v_count),
        .gen_reset      (gen_reset),
        .width          (width),
        .height         (height),
        .video_enable   (video_enable),
        .mode_locked    (mode_locked),
        .cur_mode       (cur_mode),
        .req_err        (req_err),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        vld;
        logic [2:0]  id;
        logic        gr;
        logic        rdy;
        logic        ve;
        logic        lk;
        logic [1:0]  cm;
        int          w;
        int          ht;
        logic        re;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int h, input int v, input bit vld, input int id,
                       input bit gr, input bit rdy, input bit ve, input bit lk,
                       input int cm, input int w, input int ht, input bit re);
        vec_t r;
        r.h = 12'(h); r.v = 12'(v); r.vld = vld; r.id = 3'(id);
        r.gr = gr; r.rdy = rdy; r.ve = ve; r.lk = lk;
        r.cm = 2'(cm); r.w = w; r.ht = ht; r.re = re;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input int idx, input bit gr, input bit rdy, input bit ve, input bit lk,
                            input int cm, input int w, input int ht, input bit re);
        chk("gen_reset", idx, 32'(gen_reset), 32'(gr));
        chk("ready", idx, 32'(mode_req_ready), 32'(rdy));
        chk("video_enable", idx, 32'(video_enable), 32'(ve));
        chk("mode_locked", idx, 32'(mode_locked), 32'(lk));
        chk("cur_mode", idx, 32'(cur_mode), 32'(cm));
        chk("width", idx, width, 32'(w));
        chk("height", idx, height, 32'(ht));
        chk("req_err", idx, 32'(req_err), 32'(re));
        chk("timeout_err", idx, 32'(timeout_err), 32'd0);
    endtask

    task automatic drive(input int h, input int v, input bit vld, input int id);
        gen_h_count = 12'(h); gen_v_count = 12'(v);
        mode_req_valid = vld; mode_req_id = 3'(id);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // after release: 3 more GEN_RST cycles, then SETTLE and lock on the 2nd mode-0 eof
        add(0, 0, 0, 0,       1, 0, 0, 0, 0, 640, 480, 0);
        add(0, 0, 0, 0,       1, 0, 0, 0, 0, 640, 480, 0);
        add(0, 0, 0, 0,       1, 0, 0, 0, 0, 640, 480, 0);
        add(0, 0, 0, 0,       0, 0, 0, 0, 0, 640, 480, 0);
        add(1343, 805, 0, 0,  0, 0, 0, 0, 0, 640, 480, 0);
        add(799, 0, 0, 0,     0, 0, 0, 0, 0, 640, 480, 0);
        add(799, 524, 0, 0,   0, 0, 0, 0, 0, 640, 480, 0);
        add(0, 0, 0, 0,       0, 0, 0, 0, 0, 640, 480, 0);
        add(799, 524, 0, 0,   0, 1, 1, 1, 0, 640, 480, 0);
        // invalid id, then same id
        add(0, 0, 1, 6,       0, 1, 1, 1, 0, 640, 480, 1);
        add(0, 0, 0, 0,       0, 1, 1, 1, 0, 640, 480, 0);
        add(0, 0, 1, 0,       0, 1, 1, 1, 0, 640, 480, 0);
        add(0, 0, 0, 0,       0, 1, 1, 1, 0, 640, 480, 0);
        // change to mode 2
        add(0, 0, 1, 2,       0, 0, 0, 0, 0, 640, 480, 0);
        add(0, 0, 1, 5,       0, 0, 0, 0, 0, 640, 480, 0);
        add(1343, 805, 0, 0,  0, 0, 0, 0, 0, 640, 480, 0);
        add(799, 524, 0, 0,   1, 0, 0, 0, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       1, 0, 0, 0, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       1, 0, 0, 0, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       1, 0, 0, 0, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       0, 0, 0, 0, 2, 1024, 768, 0);
        add(799, 524, 0, 0,   0, 0, 0, 0, 2, 1024, 768, 0);
        add(1343, 805, 0, 0,  0, 0, 0, 0, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       0, 0, 0, 0, 2, 1024, 768, 0);
        add(1343, 805, 0, 0,  0, 1, 1, 1, 2, 1024, 768, 0);
        add(0, 0, 0, 0,       0, 1, 1, 1, 2, 1024, 768, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_outs(-1, 1, 0, 0, 0, 0, 640, 480, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].vld, vecs[i].id);
            tick();
            chk_outs(i, vecs[i].gr, vecs[i].rdy, vecs[i].ve, vecs[i].lk,
                     vecs[i].cm, vecs[i].w, vecs[i].ht, vecs[i].re);
        end

        // change to mode 3, then reset while settling
        drive(0, 0, 1, 3);
        tick();
        chk_outs(100, 0, 0, 0, 0, 2, 1024, 768, 0);
        drive(1343, 805, 0, 0);
        tick();
        chk_outs(101, 1, 0, 0, 0, 3, 1280, 960, 0);
        drive(0, 0, 0, 0);
        repeat (4) tick();
        chk_outs(102, 0, 0, 0, 0, 3, 1280, 960, 0);
        drive(1711, 993, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk_outs(103, 1, 0, 0, 0, 0, 640, 480, 0);
        tick();
        tick();
        reset = 1'b0;

        n = 0;
        while (gen_reset && n < 20) begin
            n++;
            tick();
        end
        chk("relock_reset_len", 104, 32'(n), 32'd4);

        drive(1711, 993, 0, 0);
        tick();
        drive(799, 524, 0, 0);
        tick();
        chk_outs(105, 0, 0, 0, 0, 0, 640, 480, 0);
        drive(0, 0, 0, 0);
        tick();
        drive(799, 524, 0, 0);
        n = 0;
        while (!mode_locked && n < 5) begin
            n++;
            tick();
        end
        chk("relock_wait", 106, 32'(n), 32'd1);
        chk_outs(107, 0, 1, 1, 1, 0, 640, 480, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
